// File: rtl/apb_master_bridge_if.sv
// rtl/apb_master_bridge_if.sv - command/response and APB signal bundle for apb_master_bridge
//
// Signal names carry the bridge's point of view (_i = into the bridge, _o = out of it).
//   master modport : the bridge itself
//   slave modport  : the environment (command source, response sink, APB completer)
// Signals:
//   cmd_valid_i / cmd_ready_o / cmd_write_i / cmd_addr_i / cmd_wdata_i   command port
//   rsp_valid_o / rsp_ready_i / rsp_rdata_o / rsp_err_o / rsp_timeout_o response port
//   busy_o                                                               bridge not idle
//   psel_o / penable_o / pwrite_o / paddr_o / pwdata_o                   APB request
//   prdata_i / pready_i / pslverr_i                                      APB completion
interface apb_master_bridge_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              cmd_valid_i;
    logic              cmd_ready_o;
    logic              cmd_write_i;
    logic [ADDR_W-1:0] cmd_addr_i;
    logic [DATA_W-1:0] cmd_wdata_i;

    logic              rsp_valid_o;
    logic              rsp_ready_i;
    logic [DATA_W-1:0] rsp_rdata_o;
    logic              rsp_err_o;
    logic              rsp_timeout_o;

    logic              busy_o;

    logic              psel_o;
    logic              penable_o;
    logic              pwrite_o;
    logic [ADDR_W-1:0] paddr_o;
    logic [DATA_W-1:0] pwdata_o;
    logic [DATA_W-1:0] prdata_i;
    logic              pready_i;
    logic              pslverr_i;

    modport master (
        input  cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_wdata_i,
        input  rsp_ready_i,
        input  prdata_i, pready_i, pslverr_i,
        output cmd_ready_o,
        output rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o,
        output busy_o,
        output psel_o, penable_o, pwrite_o, paddr_o, pwdata_o
    );

    modport slave (
        output cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_wdata_i,
        output rsp_ready_i,
        output prdata_i, pready_i, pslverr_i,
        input  cmd_ready_o,
        input  rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o,
        input  busy_o,
        input  psel_o, penable_o, pwrite_o, paddr_o, pwdata_o
    );
endinterface

// File: rtl/apb_master_bridge.sv
// rtl/apb_master_bridge.sv - single-outstanding valid/ready command to AMBA 3 APB requester
//
// Ports:
//   pclk_i   clock, rising edge
//   rst_n_i  asynchronous active-low reset; forces IDLE and clears every output
//   bus      apb_master_bridge_if.master: command port, response port, busy, APB bus
// Parameters:
//   ADDR_W, DATA_W  address / data widths
//   TIMEOUT_CYC     ACCESS-phase cycle limit (1..255), only used with APB_MASTER_TIMEOUT_EN
// Optional feature macro: APB_MASTER_TIMEOUT_EN
//   defined   -> ACCESS aborts after TIMEOUT_CYC cycles of pready_i low (err + timeout flagged)
//   undefined -> ACCESS waits indefinitely, rsp_timeout_o is constant 0
module apb_master_bridge #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                 pclk_i,
    input  logic                 rst_n_i,
    apb_master_bridge_if.master  bus
);

    if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_bad_timeout_cyc
        $error("apb_master_bridge: TIMEOUT_CYC must be in 1..255");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS,
        S_RESP
    } state_t;

    state_t            state_q, state_d;

    // Every output is a flop; the *_d values are computed from the next state
    // so the registered outputs line up with the state they describe.
    logic              cmd_ready_q, cmd_ready_d;
    logic              busy_q, busy_d;
    logic              psel_q, psel_d;
    logic              penable_q, penable_d;
    logic              pwrite_q, pwrite_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;

`ifdef APB_MASTER_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYC - 1);

    logic              rsp_timeout_q, rsp_timeout_d;
    logic [7:0]        tmo_cnt_q, tmo_cnt_d;
`endif

    always_ff @(posedge pclk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q       <= S_IDLE;
            cmd_ready_q   <= 1'b0;
            busy_q        <= 1'b0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
            rsp_timeout_q <= 1'b0;
            tmo_cnt_q     <= '0;
`endif
        end else begin
            state_q       <= state_d;
            cmd_ready_q   <= cmd_ready_d;
            busy_q        <= busy_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            pwrite_q      <= pwrite_d;
            paddr_q       <= paddr_d;
            pwdata_q      <= pwdata_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
`ifdef APB_MASTER_TIMEOUT_EN
            rsp_timeout_q <= rsp_timeout_d;
            tmo_cnt_q     <= tmo_cnt_d;
`endif
        end
    end

    always_comb begin
        state_d       = state_q;
        pwrite_d      = pwrite_q;
        paddr_d       = paddr_q;
        pwdata_d      = pwdata_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
`ifdef APB_MASTER_TIMEOUT_EN
        rsp_timeout_d = rsp_timeout_q;
        tmo_cnt_d     = tmo_cnt_q;
`endif

        unique case (state_q)
            S_IDLE: begin
                // cmd_ready_q is still 0 in the first cycle after reset release,
                // so acceptance is gated on the registered ready, not the state.
                if (bus.cmd_valid_i && cmd_ready_q) begin
                    pwrite_d = bus.cmd_write_i;
                    paddr_d  = bus.cmd_addr_i;
                    pwdata_d = bus.cmd_wdata_i;
                    state_d  = S_SETUP;
                end
            end

            S_SETUP: begin
                state_d = S_ACCESS;
`ifdef APB_MASTER_TIMEOUT_EN
                tmo_cnt_d = '0;
`endif
            end

            S_ACCESS: begin
                if (bus.pready_i) begin
                    rsp_rdata_d = pwrite_q ? '0 : bus.prdata_i;
                    rsp_err_d   = bus.pslverr_i;
                    rsp_valid_d = 1'b1;
`ifdef APB_MASTER_TIMEOUT_EN
                    rsp_timeout_d = 1'b0;
`endif
                    state_d     = S_RESP;
                end
`ifdef APB_MASTER_TIMEOUT_EN
                // This cycle is the TIMEOUT_CYC-th wait cycle: abort now.
                else if (tmo_cnt_q == TMO_LAST) begin
                    rsp_rdata_d   = '0;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                    rsp_valid_d   = 1'b1;
                    state_d       = S_RESP;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 8'd1;
                end
`endif
            end

            S_RESP: begin
                if (bus.rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        cmd_ready_d = (state_d == S_IDLE);
        busy_d      = (state_d != S_IDLE);
        psel_d      = (state_d == S_SETUP) || (state_d == S_ACCESS);
        penable_d   = (state_d == S_ACCESS);
    end

    assign bus.cmd_ready_o   = cmd_ready_q;
    assign bus.busy_o        = busy_q;
    assign bus.psel_o        = psel_q;
    assign bus.penable_o     = penable_q;
    assign bus.pwrite_o      = pwrite_q;
    assign bus.paddr_o       = paddr_q;
    assign bus.pwdata_o      = pwdata_q;
    assign bus.rsp_valid_o   = rsp_valid_q;
    assign bus.rsp_rdata_o   = rsp_rdata_q;
    assign bus.rsp_err_o     = rsp_err_q;
`ifdef APB_MASTER_TIMEOUT_EN
    assign bus.rsp_timeout_o = rsp_timeout_q;
`else
    assign bus.rsp_timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_apb_master_bridge.sv
// tb/tb_apb_master_bridge.sv - table-driven self-checking bench for apb_master_bridge
module tb_apb_master_bridge;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 4;

    logic pclk;
    logic rst_n;

    apb_master_bridge_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    apb_master_bridge #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TMO)) dut (
        .pclk_i  (pclk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    typedef struct {
        logic          write;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            waits;
        logic [DW-1:0] prdata;
        logic          pslverr;
        logic [DW-1:0] exp_rdata;
        logic          exp_err;
    } vec_t;

    vec_t vecs[6];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge pclk);
        #1;
    endtask

    task automatic idle_inputs;
        bus.cmd_valid_i = 1'b0;
        bus.cmd_write_i = 1'b0;
        bus.cmd_addr_i  = '0;
        bus.cmd_wdata_i = '0;
        bus.rsp_ready_i = 1'b0;
        bus.prdata_i    = '0;
        bus.pready_i    = 1'b0;
        bus.pslverr_i   = 1'b0;
    endtask

    task automatic reset_dut;
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(posedge pclk);
        #1;
        rst_n = 1'b1;
        tick();
    endtask

    // Issue one command, play an APB completer that holds pready low for
    // v.waits ACCESS cycles (driving junk prdata and pslverr=1 meanwhile),
    // then check latency, phase shape and the response.
    task automatic run_vec(input vec_t v, input int idx);
        int   lat;
        int   acc;
        logic hold_bad;
        lat      = -1;
        acc      = 0;
        hold_bad = 1'b0;
        check($sformatf("v%0d_cmd_ready", idx), 32'(bus.cmd_ready_o), 32'd1);
        bus.cmd_valid_i = 1'b1;
        bus.cmd_write_i = v.write;
        bus.cmd_addr_i  = v.addr;
        bus.cmd_wdata_i = v.wdata;
        for (int cyc = 1; cyc <= 200; cyc++) begin
            tick();
            bus.cmd_valid_i = 1'b0;
            if (cyc == 1)
                check($sformatf("v%0d_setup", idx), 32'({bus.psel_o, bus.penable_o}), 32'b10);
            if (cyc == 2)
                check($sformatf("v%0d_access", idx), 32'({bus.psel_o, bus.penable_o}), 32'b11);
            if (bus.rsp_valid_o) begin
                lat = cyc;
                break;
            end
            if (bus.psel_o) begin
                if (bus.paddr_o !== v.addr || bus.pwrite_o !== v.write || bus.pwdata_o !== v.wdata)
                    hold_bad = 1'b1;
            end
            if (bus.psel_o && bus.penable_o) begin
                if (acc == v.waits) begin
                    bus.pready_i  = 1'b1;
                    bus.prdata_i  = v.prdata;
                    bus.pslverr_i = v.pslverr;
                end else begin
                    bus.pready_i  = 1'b0;
                    bus.prdata_i  = 32'hBAD0_0000 | 32'(acc);
                    bus.pslverr_i = 1'b1;
                end
                acc++;
            end else begin
                bus.pready_i  = 1'b0;
                bus.pslverr_i = 1'b0;
            end
        end
        bus.pready_i  = 1'b0;
        bus.pslverr_i = 1'b0;
        check($sformatf("v%0d_latency", idx), 32'(lat), 32'(3 + v.waits));
        check($sformatf("v%0d_penable_cycles", idx), 32'(acc), 32'(v.waits + 1));
        check($sformatf("v%0d_apb_hold", idx), 32'(hold_bad), 32'd0);
        check($sformatf("v%0d_rdata", idx), bus.rsp_rdata_o, v.exp_rdata);
        check($sformatf("v%0d_err", idx), 32'(bus.rsp_err_o), 32'(v.exp_err));
        check($sformatf("v%0d_timeout", idx), 32'(bus.rsp_timeout_o), 32'd0);
        check($sformatf("v%0d_resp_psel", idx), 32'({bus.psel_o, bus.penable_o}), 32'd0);
        bus.rsp_ready_i = 1'b1;
        tick();
        bus.rsp_ready_i = 1'b0;
        check($sformatf("v%0d_after_hs", idx),
              32'({bus.rsp_valid_o, bus.cmd_ready_o, bus.busy_o}), 32'b010);
        check($sformatf("v%0d_addr_kept", idx), bus.paddr_o, v.addr);
    endtask

    initial begin
        int bad;
        int lat;
        int acc;

        vecs[0] = '{1'b1, 32'h0000_0003, 32'h0000_000F, 0, 32'hAAAA_5555, 1'b0, 32'h0,         1'b0};
        vecs[1] = '{1'b0, 32'h0000_0001, 32'h0,         3, 32'h0000_0005, 1'b0, 32'h0000_0005, 1'b0};
        vecs[2] = '{1'b0, 32'h0000_0010, 32'h0,         0, 32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF, 1'b1};
        vecs[3] = '{1'b1, 32'h0000_0020, 32'h1234_0000, 1, 32'hAAAA_5555, 1'b0, 32'h0,         1'b0};
        vecs[4] = '{1'b1, 32'h0000_0024, 32'hFFFF_FFFF, 2, 32'h5A5A_5A5A, 1'b1, 32'h0,         1'b1};
        vecs[5] = '{1'b0, 32'h8000_0008, 32'h0,         0, 32'h1234_5678, 1'b0, 32'h1234_5678, 1'b0};

        // Reset state
        rst_n = 1'b0;
        idle_inputs();
        #3;
        check("reset_ctrl", 32'({bus.cmd_ready_o, bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_timeout_o,
                                 bus.busy_o, bus.psel_o, bus.penable_o, bus.pwrite_o}), 32'd0);
        check("reset_paddr", bus.paddr_o, 32'd0);
        check("reset_pwdata", bus.pwdata_o, 32'd0);
        check("reset_rdata", bus.rsp_rdata_o, 32'd0);
        repeat (2) @(posedge pclk);
        #1;
        rst_n = 1'b1;
        tick();
        check("ready_after_reset", 32'(bus.cmd_ready_o), 32'd1);

        // Table-driven transfers (vecs[2] is the slave error, vecs[3] the clean follow-up)
        for (int i = 0; i < 6; i++)
            run_vec(vecs[i], i);

        // Response backpressure with a second command waiting
        bus.cmd_valid_i = 1'b1;
        bus.cmd_write_i = 1'b0;
        bus.cmd_addr_i  = 32'h40;
        bus.cmd_wdata_i = 32'h0;
        tick();
        bus.cmd_write_i = 1'b1;
        bus.cmd_addr_i  = 32'h44;
        bus.cmd_wdata_i = 32'h99;
        check("bp_setup", 32'({bus.psel_o, bus.penable_o, bus.cmd_ready_o}), 32'b100);
        tick();
        bus.pready_i = 1'b1;
        bus.prdata_i = 32'hA5;
        tick();
        bus.pready_i = 1'b0;
        bus.prdata_i = 32'h0;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("bp_hold%0d_ctrl", k),
                  32'({bus.rsp_valid_o, bus.cmd_ready_o, bus.psel_o, bus.rsp_err_o}), 32'b1000);
            check($sformatf("bp_hold%0d_rdata", k), bus.rsp_rdata_o, 32'hA5);
            check($sformatf("bp_hold%0d_paddr", k), bus.paddr_o, 32'h40);
            tick();
        end
        bus.rsp_ready_i = 1'b1;
        tick();
        bus.rsp_ready_i = 1'b0;
        check("bp_idle_ready", 32'({bus.rsp_valid_o, bus.cmd_ready_o}), 32'b01);
        tick();
        bus.cmd_valid_i = 1'b0;
        check("bp_second_setup", 32'({bus.psel_o, bus.penable_o, bus.pwrite_o}), 32'b101);
        check("bp_second_addr", bus.paddr_o, 32'h44);
        check("bp_second_wdata", bus.pwdata_o, 32'h99);
        tick();
        bus.pready_i = 1'b1;
        tick();
        bus.pready_i = 1'b0;
        check("bp_second_rsp", 32'({bus.rsp_valid_o, bus.rsp_err_o}), 32'b10);
        check("bp_second_rdata", bus.rsp_rdata_o, 32'h0);
        bus.rsp_ready_i = 1'b1;
        tick();
        bus.rsp_ready_i = 1'b0;

        // pready never arrives
        bus.cmd_valid_i = 1'b1;
        bus.cmd_write_i = 1'b0;
        bus.cmd_addr_i  = 32'h50;
        tick();
        bus.cmd_valid_i = 1'b0;
        bus.pslverr_i   = 1'b1;
        bus.prdata_i    = 32'hCAFE_F00D;
`ifdef APB_MASTER_TIMEOUT_EN
        lat = -1;
        acc = 0;
        for (int cyc = 2; cyc <= 60; cyc++) begin
            tick();
            if (bus.rsp_valid_o) begin
                lat = cyc;
                break;
            end
            if (bus.penable_o) acc++;
        end
        check("tmo_latency", 32'(lat), 32'(2 + TMO));
        check("tmo_access_cycles", 32'(acc), 32'(TMO));
        check("tmo_flags", 32'({bus.rsp_err_o, bus.rsp_timeout_o, bus.psel_o}), 32'b110);
        check("tmo_rdata", bus.rsp_rdata_o, 32'h0);
        bus.pslverr_i   = 1'b0;
        bus.rsp_ready_i = 1'b1;
        tick();
        bus.rsp_ready_i = 1'b0;
        check("tmo_back_idle", 32'(bus.cmd_ready_o), 32'd1);
`else
        bad = 0;
        for (int cyc = 0; cyc < 120; cyc++) begin
            tick();
            if (!(bus.psel_o && bus.penable_o) || bus.rsp_valid_o) bad++;
        end
        check("stall_held_cycles_bad", 32'(bad), 32'd0);
        check("stall_timeout_flag", 32'(bus.rsp_timeout_o), 32'd0);
        reset_dut();
        check("stall_cleared_ready", 32'(bus.cmd_ready_o), 32'd1);
`endif

        // Asynchronous reset during ACCESS wait states
        idle_inputs();
        bus.cmd_valid_i = 1'b1;
        bus.cmd_addr_i  = 32'h60;
        tick();
        bus.cmd_valid_i = 1'b0;
        repeat (3) tick();
        check("pre_reset_access", 32'({bus.psel_o, bus.penable_o, bus.busy_o}), 32'b111);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_zero", 32'({bus.psel_o, bus.penable_o, bus.rsp_valid_o,
                                       bus.busy_o, bus.cmd_ready_o}), 32'd0);
        repeat (2) @(posedge pclk);
        #1;
        rst_n = 1'b1;
        tick();
        check("ready_after_mid_reset", 32'(bus.cmd_ready_o), 32'd1);
        run_vec(vecs[1], 6);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
